// File: rtl/sum_sq_accum.sv
// Streaming sum-of-squares accumulator feeding the Q16.16 sqrt stage over a level valid/ready handshake.
// Optional build macro SUMSQ_SAT_EN: saturate sum_out to all-ones once the accumulation overflows.
module sum_sq_accum #(
  parameter int ELEM_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic signed [ELEM_W-1:0] elem_in,
  input  logic                     elem_valid,
  input  logic                     elem_last,
  output logic                     elem_ready,
  output logic [31:0]              sum_out,
  output logic                     sum_valid,
  input  logic                     sqrt_ready,
  output logic [CNT_W-1:0]         elem_count,
  output logic                     overflow
);

  localparam logic [1:0] ST_ACCUM   = 2'd0;
  localparam logic [1:0] ST_FLUSH   = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  logic [1:0]               r_state;
  logic [1:0]               w_state_next;
  logic                     w_accept;
  logic                     w_clear;

  logic signed [ELEM_W-1:0] r_elem_p0;
  logic                     r_vld_p0;
  logic                     r_last_p0;

  logic [31:0]              r_sq_p1;
  logic                     r_vld_p1;
  logic                     r_last_p1;

  logic [32:0]              r_acc_p2;
  logic [32:0]              w_acc_next;
  logic [CNT_W-1:0]         r_cnt_p2;
  logic                     r_ovf_p2;
  logic                     r_vld_p2;
  logic                     r_last_p2;

  // The square of any signed ELEM_W value is non-negative, so zero-extending it is exact.
  function automatic logic [31:0] square_u32(input logic signed [ELEM_W-1:0] x);
    logic signed [2*ELEM_W-1:0] xe;
    logic signed [2*ELEM_W-1:0] p;
    xe = (2*ELEM_W)'(x);
    p  = xe * xe;
    return 32'($unsigned(p));
  endfunction

`ifdef SUMSQ_SAT_EN
  function automatic logic [31:0] sat_sum(input logic [31:0] wrapped, input logic ovf);
    return ovf ? 32'hFFFF_FFFF : wrapped;
  endfunction
`endif

  assign elem_ready = (r_state == ST_ACCUM) && !reset;
  assign w_accept   = elem_valid && elem_ready;
  assign w_clear    = (r_state == ST_RELEASE) && !sqrt_ready;
  assign w_acc_next = r_acc_p2 + {1'b0, r_sq_p1};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ACCUM:   if (w_accept && elem_last)  w_state_next = ST_FLUSH;
      ST_FLUSH:   if (r_vld_p2 && r_last_p2)  w_state_next = ST_HOLD;
      ST_HOLD:    if (sqrt_ready)             w_state_next = ST_RELEASE;
      ST_RELEASE: if (!sqrt_ready)            w_state_next = ST_ACCUM;
      default:                                w_state_next = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_ACCUM;
    else       r_state <= w_state_next;
  end

  // Stage p0: capture the accepted element
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld_p0  <= 1'b0;
      r_last_p0 <= 1'b0;
    end else begin
      r_vld_p0  <= w_accept;
      r_last_p0 <= w_accept && elem_last;
    end
  end

  always_ff @(posedge clock) begin
    if (w_accept) r_elem_p0 <= elem_in;
  end

  // Stage p1: square
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
    end else begin
      r_vld_p1  <= r_vld_p0;
      r_last_p1 <= r_last_p0;
    end
  end

  always_ff @(posedge clock) begin
    r_sq_p1 <= square_u32(r_elem_p0);
  end

  // Stage p2: accumulate, count and flag overflow; cleared on every return to ACCUM
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld_p2  <= 1'b0;
      r_last_p2 <= 1'b0;
      r_acc_p2  <= '0;
      r_cnt_p2  <= '0;
      r_ovf_p2  <= 1'b0;
    end else begin
      r_vld_p2  <= r_vld_p1;
      r_last_p2 <= r_last_p1;
      if (w_clear) begin
        r_acc_p2 <= '0;
        r_cnt_p2 <= '0;
        r_ovf_p2 <= 1'b0;
      end else if (r_vld_p1) begin
        r_acc_p2 <= w_acc_next;
        if (r_cnt_p2 != '1) r_cnt_p2 <= r_cnt_p2 + CNT_W'(1);
        r_ovf_p2 <= r_ovf_p2 | w_acc_next[32];
      end
    end
  end

  // Pipeline is empty in HOLD/RELEASE, so these outputs are frozen while sum_valid is high.
`ifdef SUMSQ_SAT_EN
  assign sum_out = sat_sum(r_acc_p2[31:0], r_ovf_p2);
`else
  assign sum_out = r_acc_p2[31:0];
`endif
  assign sum_valid  = (r_state == ST_HOLD);
  assign elem_count = r_cnt_p2;
  assign overflow   = r_ovf_p2;

endmodule

// File: tb/tb_sum_sq_accum.sv
// Self-checking bench for sum_sq_accum: directed scenarios plus randomized vectors against a sum-of-squares model.
module tb_sum_sq_accum;
  localparam int ELEM_W = 16;
  localparam int CNT_W  = 8;
  localparam longint unsigned TWO32 = 64'h1_0000_0000;

  logic                     clock = 1'b0;
  logic                     reset = 1'b1;
  logic signed [ELEM_W-1:0] elem_in = '0;
  logic                     elem_valid = 1'b0;
  logic                     elem_last = 1'b0;
  logic                     elem_ready;
  logic [31:0]              sum_out;
  logic                     sum_valid;
  logic                     sqrt_ready = 1'b0;
  logic [CNT_W-1:0]         elem_count;
  logic                     overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  sum_sq_accum #(.ELEM_W(ELEM_W), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .elem_in    (elem_in),
    .elem_valid (elem_valid),
    .elem_last  (elem_last),
    .elem_ready (elem_ready),
    .sum_out    (sum_out),
    .sum_valid  (sum_valid),
    .sqrt_ready (sqrt_ready),
    .elem_count (elem_count),
    .overflow   (overflow)
  );

  // Reference model: plain integer arithmetic over the whole vector
  function automatic longint unsigned ref_total(input int q[$]);
    longint unsigned t;
    t = 0;
    foreach (q[i]) t += longint'(q[i]) * longint'(q[i]);
    return t;
  endfunction

  function automatic logic [31:0] ref_sum(input int q[$]);
    longint unsigned t;
    t = ref_total(q);
`ifdef SUMSQ_SAT_EN
    if (t >= TWO32) return 32'hFFFF_FFFF;
`endif
    return t[31:0];
  endfunction

  function automatic logic [CNT_W-1:0] ref_cnt(input int q[$]);
    if (q.size() >= (1 << CNT_W) - 1) return '1;
    return CNT_W'(q.size());
  endfunction

  function automatic logic ref_ovf(input int q[$]);
    return ref_total(q) >= TWO32;
  endfunction

  // Behaviour of the downstream sqrt stage: floor(sqrt(n)) in Q16.16
  function automatic logic [31:0] sqrt_q16(input logic [31:0] n);
    longint unsigned x, r, c;
    x = {n, 32'h0};
    r = 0;
    for (int b = 31; b >= 0; b--) begin
      c = r | (64'd1 << b);
      if (c * c <= x) r = c;
    end
    return r[31:0];
  endfunction

  task automatic send_vec(input int q[$], input bit keep_valid, output int acc_cyc, output bit ok);
    ok = 1'b1;
    acc_cyc = 0;
    for (int i = 0; i < q.size(); i++) begin
      bit took;
      int guard;
      took  = 1'b0;
      guard = 0;
      elem_in    = q[i][ELEM_W-1:0];
      elem_valid = 1'b1;
      elem_last  = (i == q.size() - 1);
      while (!took && guard < 500) begin
        took = elem_ready;
        @(negedge clock);
        guard++;
      end
      if (!took) ok = 1'b0;
      acc_cyc = cyc;
    end
    if (!keep_valid) begin
      elem_valid = 1'b0;
      elem_last  = 1'b0;
    end
  endtask

  task automatic await_sum(input int budget, output int rise_cyc, output bit got);
    got = 1'b0;
    rise_cyc = 0;
    for (int k = 0; k < budget && !got; k++) begin
      if (sum_valid) begin
        got = 1'b1;
        rise_cyc = cyc;
      end else begin
        @(negedge clock);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_tests++; if (elem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", elem_ready); end
    n_tests++; if (sum_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", sum_valid); end
    n_tests++; if (sum_out !== 32'h0) begin n_fail++; $display("FAIL reset_sum: got %0h want 0", sum_out); end
    n_tests++; if (elem_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", elem_count); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    reset = 1'b0;
    @(negedge clock);
    n_tests++; if (elem_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b want 1", elem_ready); end
  endtask

  task automatic test_basic();
    int q[$];
    int acc, rise;
    bit ok, got;
    q.push_back(3); q.push_back(4);
    send_vec(q, 1'b0, acc, ok);
    await_sum(20, rise, got);
    n_tests++; if (!ok || !got) begin n_fail++; $display("FAIL basic_handshake: accepted %b presented %b want 1 1", ok, got); end
    n_tests++; if (rise - acc != 3) begin n_fail++; $display("FAIL basic_latency: got %0d want 3", rise - acc); end
    n_tests++; if (sum_out !== ref_sum(q)) begin n_fail++; $display("FAIL basic_sum: got %0h want %0h", sum_out, ref_sum(q)); end
    n_tests++; if (elem_count !== ref_cnt(q)) begin n_fail++; $display("FAIL basic_count: got %0d want %0d", elem_count, ref_cnt(q)); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b want 0", overflow); end
    n_tests++; if (sqrt_q16(sum_out) !== 32'h0005_0000) begin n_fail++; $display("FAIL basic_sqrt: got %0h want 50000", sqrt_q16(sum_out)); end
    sqrt_ready = 1'b1;
    @(negedge clock);
    n_tests++; if (sum_valid !== 1'b0) begin n_fail++; $display("FAIL basic_release: got %b want 0", sum_valid); end
    sqrt_ready = 1'b0;
    @(negedge clock);
    n_tests++; if (elem_count !== '0 || elem_ready !== 1'b1) begin n_fail++; $display("FAIL basic_reentry: count %0d ready %b want 0 1", elem_count, elem_ready); end
  endtask

  task automatic test_single_ready_high();
    int q[$];
    int acc, rise;
    bit ok, got;
    q.push_back(-32768);
    sqrt_ready = 1'b1;
    send_vec(q, 1'b0, acc, ok);
    await_sum(20, rise, got);
    n_tests++; if (!ok || !got || rise - acc != 3) begin n_fail++; $display("FAIL single_latency: got %0d want 3", rise - acc); end
    n_tests++; if (sum_out !== 32'h4000_0000) begin n_fail++; $display("FAIL single_sum: got %0h want 40000000", sum_out); end
    n_tests++; if (elem_count !== 8'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", elem_count); end
    n_tests++; if (sqrt_q16(sum_out) !== 32'h8000_0000) begin n_fail++; $display("FAIL single_sqrt: got %0h want 80000000", sqrt_q16(sum_out)); end
    @(negedge clock);
    n_tests++; if (sum_valid !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle: got %b want 0", sum_valid); end
    sqrt_ready = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_overflow();
    int q[$];
    int acc, rise;
    bit ok, got;
    repeat (5) q.push_back(-32768);
    send_vec(q, 1'b0, acc, ok);
    await_sum(20, rise, got);
    n_tests++; if (!ok || !got) begin n_fail++; $display("FAIL ovf_handshake: accepted %b presented %b want 1 1", ok, got); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_tests++; if (sum_out !== ref_sum(q)) begin n_fail++; $display("FAIL ovf_sum: got %0h want %0h", sum_out, ref_sum(q)); end
    n_tests++; if (elem_count !== 8'd5) begin n_fail++; $display("FAIL ovf_count: got %0d want 5", elem_count); end
    sqrt_ready = 1'b1;
    @(negedge clock);
    sqrt_ready = 1'b0;
    @(negedge clock);
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_hold_stall();
    int q[$];
    int q2[$];
    int acc, rise;
    bit ok, got;
    logic [31:0] exp;
    q.push_back(9); q.push_back(10);
    exp = ref_sum(q);
    send_vec(q, 1'b0, acc, ok);
    await_sum(20, rise, got);
    n_tests++; if (!ok || !got) begin n_fail++; $display("FAIL stall_handshake: accepted %b presented %b want 1 1", ok, got); end
    elem_in = 16'sd7; elem_valid = 1'b1; elem_last = 1'b0;
    for (int k = 0; k < 10; k++) begin
      n_tests++;
      if (sum_valid !== 1'b1 || sum_out !== exp || elem_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: valid %b sum %0h ready %b want 1 %0h 0", sum_valid, sum_out, elem_ready, exp);
      end
      @(negedge clock);
    end
    sqrt_ready = 1'b1;
    @(negedge clock);
    sqrt_ready = 1'b0;
    @(negedge clock);
    n_tests++; if (elem_ready !== 1'b1) begin n_fail++; $display("FAIL stall_reentry: got %b want 1", elem_ready); end
    q2.push_back(7); q2.push_back(1);
    send_vec(q2, 1'b0, acc, ok);
    await_sum(20, rise, got);
    n_tests++; if (!got || sum_out !== ref_sum(q2) || elem_count !== 8'd2) begin n_fail++; $display("FAIL stall_next: sum %0h count %0d want %0h 2", sum_out, elem_count, ref_sum(q2)); end
    sqrt_ready = 1'b1;
    @(negedge clock);
    sqrt_ready = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int q[$];
    int q2[$];
    int acc, rise;
    bit ok, got, seen;
    q.push_back(5); q.push_back(5);
    send_vec(q, 1'b0, acc, ok);
    reset = 1'b1;
    seen = 1'b0;
    repeat (2) begin @(negedge clock); if (sum_valid) seen = 1'b1; end
    reset = 1'b0;
    repeat (8) begin @(negedge clock); if (sum_valid) seen = 1'b1; end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midreset_no_pulse: got %b want 0", seen); end
    n_tests++; if (sum_out !== 32'h0 || elem_count !== '0 || overflow !== 1'b0) begin n_fail++; $display("FAIL midreset_outputs: sum %0h count %0d ovf %b want 0 0 0", sum_out, elem_count, overflow); end
    q2.push_back(1);
    send_vec(q2, 1'b0, acc, ok);
    await_sum(20, rise, got);
    n_tests++; if (!got || sum_out !== 32'd1 || elem_count !== 8'd1) begin n_fail++; $display("FAIL midreset_next: sum %0h count %0d want 1 1", sum_out, elem_count); end
    sqrt_ready = 1'b1;
    @(negedge clock);
    sqrt_ready = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int qa[$];
    int qb[$];
    logic [31:0] exp_s[2];
    int a_acc, b_acc;
    bit ok1, ok2, seen;
    qa.push_back(1); qa.push_back(2);
    qb.push_back(2); qb.push_back(2);
    exp_s[0] = ref_sum(qa);
    exp_s[1] = ref_sum(qb);
    fork
      begin
        send_vec(qa, 1'b1, a_acc, ok1);
        send_vec(qb, 1'b0, b_acc, ok2);
      end
      begin
        for (int s = 0; s < 2; s++) begin
          int rise;
          bit got;
          await_sum(40, rise, got);
          n_tests++; if (!got || sum_out !== exp_s[s]) begin n_fail++; $display("FAIL b2b_sum%0d: got %0h want %0h", s, sum_out, exp_s[s]); end
          n_tests++; if (elem_count !== 8'd2 || overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_count%0d: count %0d ovf %b want 2 0", s, elem_count, overflow); end
          sqrt_ready = 1'b1;
          @(negedge clock);
          sqrt_ready = 1'b0;
          @(negedge clock);
          n_tests++; if (elem_count !== '0 || overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_clear%0d: count %0d ovf %b want 0 0", s, elem_count, overflow); end
        end
      end
    join
    n_tests++; if (!ok1 || !ok2) begin n_fail++; $display("FAIL b2b_accept: got %b%b want 11", ok1, ok2); end
    seen = 1'b0;
    repeat (8) begin @(negedge clock); if (sum_valid) seen = 1'b1; end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL b2b_extra_pulse: got %b want 0", seen); end
  endtask

  task automatic test_random();
    for (int v = 0; v < 8; v++) begin
      int q[$];
      int len, acc, rise, d;
      bit ok, got, stable;
      logic [31:0] exp;
      len = (v == 7) ? 260 : int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 4))
          0:       q.push_back(-32768);
          1:       q.push_back(32767);
          default: q.push_back(int'($urandom_range(0, 65535)) - 32768);
        endcase
      end
      exp = ref_sum(q);
      send_vec(q, 1'b0, acc, ok);
      await_sum(20, rise, got);
      n_tests++; if (!ok || !got || rise - acc != 3) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want 3", v, rise - acc); end
      n_tests++; if (sum_out !== exp) begin n_fail++; $display("FAIL rand%0d_sum: got %0h want %0h", v, sum_out, exp); end
      n_tests++; if (elem_count !== ref_cnt(q) || overflow !== ref_ovf(q)) begin n_fail++; $display("FAIL rand%0d_flags: count %0d ovf %b want %0d %b", v, elem_count, overflow, ref_cnt(q), ref_ovf(q)); end
      d = int'($urandom_range(0, 3));
      stable = 1'b1;
      repeat (d) begin @(negedge clock); if (sum_valid !== 1'b1 || sum_out !== exp) stable = 1'b0; end
      n_tests++; if (stable !== 1'b1) begin n_fail++; $display("FAIL rand%0d_stable: got %b want 1", v, stable); end
      sqrt_ready = 1'b1;
      @(negedge clock);
      sqrt_ready = 1'b0;
      @(negedge clock);
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_basic();
    test_single_ready_high();
    test_overflow();
    test_hold_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/sum_sq_accum.md
Name: sum_sq_accum

Overview:
- Streaming sum-of-squares accumulator; sits directly upstream of the integer-to-Q16.16 square-root stage.
- Accepts one signed vector element per cycle. Squares and accumulates the elements until the element tagged last.
- Presents the 32-bit sum to the sqrt stage using its level handshake: valid held until ready is seen, then released.
- Used for Euclidean-norm / vector-magnitude computation.

Parameters:
- ELEM_W, 16, signed element width; must be ≤16 so one square fits in 32 bits.
- CNT_W, 8, width of the element counter; count saturates at 2^CNT_W-1.

Ports:
- clock  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- elem_in  input  ELEM_W  signed two's-complement element.
- elem_valid  input  1  elem_in is valid this cycle.
- elem_last  input  1  qualifies elem_in as the final element of the vector.
- elem_ready  output  1  block accepts an element this cycle.
- sum_out  output  32  unsigned sum of squares; connects to the sqrt data_in.
- sum_valid  output  1  sum_out valid; connects to the sqrt data_valid.
- sqrt_ready  input  1  sqrt data_ready.
- elem_count  output  CNT_W  number of elements in the presented sum.
- overflow  output  1  32-bit accumulation overflowed for the presented sum.

Behaviour:
- Reset values: sum_out=0, sum_valid=0, elem_ready=0 during reset and 1 the cycle after, elem_count=0, overflow=0, state=ACCUM, accumulator=0, pipeline valid=0.
- An element is accepted when elem_valid && elem_ready.
- States:
  - ACCUM: elem_ready=1. Accepted elements enter the pipeline.
  - FLUSH: elem_ready=0. Waits for the last element to leave the pipeline.
  - HOLD: sum_valid=1. sum_out, elem_count and overflow are frozen.
  - RELEASE: sum_valid=0. Waits for sqrt_ready=0.
- Pipeline:
  - Stage 1 registers sq = elem_in*elem_in, computed as signed×signed then taken as 32-bit unsigned. Maximum is 2^30 for -2^(ELEM_W-1) at ELEM_W=16.
  - Stage 2 adds sq into a 33-bit accumulator.
  - The last flag travels with the element.
- Transitions:
  - ACCUM→FLUSH on accepting an element with elem_last=1.
  - FLUSH→HOLD when the last element's square has been added. sum_valid rises exactly 3 cycles after the accept edge.
  - HOLD→RELEASE on sqrt_ready=1 sampled high; sum_valid drops the next cycle.
  - RELEASE→ACCUM when sqrt_ready=0.
  - On entering ACCUM, the accumulator, elem_count and overflow clear in the same cycle. elem_ready=1 in that cycle.
- elem_count:
  - Increments at stage 2.
  - Saturates at all-ones; does not wrap.
  - A single-element vector gives elem_count=1.
- overflow: set when bit 32 of the accumulator becomes 1. Sticky until the next ACCUM entry.
- A single-element vector (elem_last on the first element) is legal.
- Zero-length vectors are not representable.
- elem_valid while elem_ready=0: element not consumed; upstream must hold it.
- sqrt_ready already high when entering HOLD: transition to RELEASE on the next edge. sum_valid is high for exactly 1 cycle.
- Reset mid-operation, in any state, including with elements in the pipeline: all state is discarded and reset values apply on the next cycle. No partial sum is emitted.
- Never assert sum_valid while sum_out is changing.

Optional Feature:
- Macro SUMSQ_SAT_EN.
- Defined: on overflow, sum_out saturates to 32'hFFFF_FFFF and stays there for the rest of the vector.
- Undefined: sum_out is the accumulator modulo 2^32 (wraps).
- overflow flag behaviour is identical in both builds.

Test Plan:
- Vector {3, 4(last)} with sqrt_ready tied to the real sqrt stage → sum_out=25, elem_count=2, overflow=0; sqrt data_out=0x0005_0000. sum_valid rises 3 cycles after accepting the 4.
- Single element {-32768(last)} → sum_out=0x4000_0000, elem_count=1; sqrt data_out=0x8000_0000.
- Five elements of -32768, last on the 5th → overflow=1.
  - SUMSQ_SAT_EN defined: sum_out=0xFFFF_FFFF.
  - SUMSQ_SAT_EN undefined: sum_out=0x4000_0000.
- sqrt_ready held 0 for 10 cycles in HOLD while elem_valid=1 with data 7 → sum_out stable, sum_valid=1, elem_ready=0, no element consumed. After sqrt_ready pulses 1→0, the held 7 is accepted as the first element of the next vector.
- Reset asserted one cycle after accepting {5, 5(last)} → no sum_valid pulse, all outputs 0. The next vector {1(last)} yields sum_out=1, elem_count=1.
- Back-to-back vectors {1, 2(last)} then {2, 2(last)} with elem_valid always 1 → sums 5 then 8, each presented once. elem_count and overflow clear between vectors.
